// File: rtl/sync_ram_ctrl_pkg.sv
// Shared definitions for the synchronous_ram request front-end.
// Contents: controller FSM state encoding, default parameter values, and the
// request-record width helper (we + addr + wdata).
package sync_ram_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    RD_WAIT = 2'd2,
    RSP     = 2'd3
  } ctrlState_t;

  localparam int unsigned DEF_ADDR_SIZE   = 2;
  localparam int unsigned DEF_DATA_SIZE   = 8;
  localparam int unsigned DEF_QDEPTH_LOG2 = 1;
  localparam int unsigned DEF_RD_LATENCY  = 1;

  // Queued request record is {we, addr, wdata}.
  function automatic int unsigned reqWidth(input int unsigned addrSize,
                                           input int unsigned dataSize);
    return 1 + addrSize + dataSize;
  endfunction

endpackage

// File: rtl/sync_ram_ctrl_if.sv
// Request/response port of the synchronous_ram front-end.
// Signals: req_valid/req_ready/req_we/req_addr/req_wdata (request channel),
//          rsp_valid/rsp_ready/rsp_data (read response channel).
// Modports: master = requesting client, slave = controller.
interface sync_ram_ctrl_if
  import sync_ram_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_SIZE = DEF_ADDR_SIZE,
  parameter int unsigned DATA_SIZE = DEF_DATA_SIZE
) ();

  logic                 req_valid;
  logic                 req_ready;
  logic                 req_we;
  logic [ADDR_SIZE-1:0] req_addr;
  logic [DATA_SIZE-1:0] req_wdata;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [DATA_SIZE-1:0] rsp_data;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_data
  );

endinterface

// File: rtl/sync_ram_req_fifo.sv
// In-order request queue, 2**QDEPTH_LOG2 entries of WIDTH bits.
// Ports: clk, reset (async, active-high), push/din (write, ignored when full),
//        pop (discard head, ignored when empty), full, empty, head (current
//        oldest entry, combinational).
// Pointers carry one extra wrap bit so full/empty are told apart by the MSB.
module sync_ram_req_fifo #(
  parameter int unsigned WIDTH       = 11,
  parameter int unsigned QDEPTH_LOG2 = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int unsigned DEPTH = 1 << QDEPTH_LOG2;
  localparam int unsigned PTR_W = QDEPTH_LOG2 + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wrPtr;
  logic [PTR_W-1:0] rdPtr;
  logic             doPush;
  logic             doPop;

  assign empty  = (wrPtr == rdPtr);
  assign full   = (wrPtr[QDEPTH_LOG2] != rdPtr[QDEPTH_LOG2]) &&
                  (wrPtr[QDEPTH_LOG2-1:0] == rdPtr[QDEPTH_LOG2-1:0]);
  assign doPush = push && !full;
  assign doPop  = pop && !empty;
  assign head   = mem[rdPtr[QDEPTH_LOG2-1:0]];

  // Pointer update; wraps modulo 2*DEPTH.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + PTR_W'(1);
      if (doPop)  rdPtr <= rdPtr + PTR_W'(1);
    end
  end

  // Storage; contents are don't-care until pushed, so no reset.
  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtr[QDEPTH_LOG2-1:0]] <= din;
  end

endmodule

// File: rtl/sync_ram_ctrl.sv
// Request front-end for synchronous_ram: queues read/write requests and issues
// them to the RAM one at a time, returning read data in request order.
// Ports: clk, reset (async, active-high),
//        bus      (sync_ram_ctrl_if.slave: request + read response channels),
//        ram_cs/ram_we/ram_rd/ram_addr/ram_din (registered RAM strobes/data),
//        ram_dout (RAM read data, valid RD_LATENCY clocks after the RD edge).
module sync_ram_ctrl
  import sync_ram_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_SIZE   = DEF_ADDR_SIZE,
  parameter int unsigned DATA_SIZE   = DEF_DATA_SIZE,
  parameter int unsigned QDEPTH_LOG2 = DEF_QDEPTH_LOG2,
  parameter int unsigned RD_LATENCY  = DEF_RD_LATENCY
) (
  input  logic                 clk,
  input  logic                 reset,
  sync_ram_ctrl_if.slave       bus,
  output logic                 ram_cs,
  output logic                 ram_we,
  output logic                 ram_rd,
  output logic [ADDR_SIZE-1:0] ram_addr,
  output logic [DATA_SIZE-1:0] ram_din,
  input  logic [DATA_SIZE-1:0] ram_dout
);

  localparam int unsigned REQ_W = reqWidth(ADDR_SIZE, DATA_SIZE);
  localparam int unsigned CNT_W = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;

  ctrlState_t           state;
  ctrlState_t           stateNext;
  logic [CNT_W-1:0]     cnt;
  logic [CNT_W-1:0]     cntNext;
  logic                 csNext;
  logic                 weNext;
  logic                 rdNext;
  logic [ADDR_SIZE-1:0] addrNext;
  logic [DATA_SIZE-1:0] dinNext;
  logic                 rspValid;
  logic                 rspValidNext;
  logic [DATA_SIZE-1:0] rspData;
  logic [DATA_SIZE-1:0] rspDataNext;

  logic                 qPush;
  logic                 qPop;
  logic                 qFull;
  logic                 qEmpty;
  logic [REQ_W-1:0]     qHead;
  logic                 headWe;
  logic [ADDR_SIZE-1:0] headAddr;
  logic [DATA_SIZE-1:0] headData;

  assign qPush                        = bus.req_valid && !qFull;
  assign qPop                         = (state == IDLE) && !qEmpty;
  assign {headWe, headAddr, headData} = qHead;

  assign bus.req_ready = !qFull;
  assign bus.rsp_valid = rspValid;
  assign bus.rsp_data  = rspData;

  sync_ram_req_fifo #(
    .WIDTH       (REQ_W),
    .QDEPTH_LOG2 (QDEPTH_LOG2)
  ) reqFifo (
    .clk   (clk),
    .reset (reset),
    .push  (qPush),
    .pop   (qPop),
    .din   ({bus.req_we, bus.req_addr, bus.req_wdata}),
    .full  (qFull),
    .empty (qEmpty),
    .head  (qHead)
  );

  // State and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      ram_cs   <= 1'b0;
      ram_we   <= 1'b0;
      ram_rd   <= 1'b0;
      ram_addr <= '0;
      ram_din  <= '0;
      rspValid <= 1'b0;
      rspData  <= '0;
    end else begin
      state    <= stateNext;
      cnt      <= cntNext;
      ram_cs   <= csNext;
      ram_we   <= weNext;
      ram_rd   <= rdNext;
      ram_addr <= addrNext;
      ram_din  <= dinNext;
      rspValid <= rspValidNext;
      rspData  <= rspDataNext;
    end
  end

  // Next-state logic.
  always_comb begin
    stateNext = state;
    unique case (state)
      IDLE:    if (!qEmpty) stateNext = ISSUE;
      ISSUE:   stateNext = ram_rd ? RD_WAIT : IDLE;
      RD_WAIT: if (cnt == '0) stateNext = RSP;
      RSP:     if (bus.rsp_ready) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Output / datapath next values; strobes default low so each lasts one clock.
  always_comb begin
    csNext       = 1'b0;
    weNext       = 1'b0;
    rdNext       = 1'b0;
    addrNext     = ram_addr;
    dinNext      = ram_din;
    cntNext      = cnt;
    rspValidNext = rspValid;
    rspDataNext  = rspData;
    unique case (state)
      IDLE: begin
        if (!qEmpty) begin
          csNext   = 1'b1;
          weNext   = headWe;
          rdNext   = !headWe;
          addrNext = headAddr;
          dinNext  = headData;
        end
      end
      ISSUE: begin
        if (ram_rd) cntNext = CNT_W'(RD_LATENCY - 1);
      end
      RD_WAIT: begin
        if (cnt == '0) begin
          rspValidNext = 1'b1;
          rspDataNext  = ram_dout;
        end else begin
          cntNext = cnt - CNT_W'(1);
        end
      end
      RSP: begin
        if (bus.rsp_ready) rspValidNext = 1'b0;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_sync_ram_ctrl.sv
// Bench for sync_ram_ctrl with a behavioural synchronous_ram model.
// The reference model tracks accepted requests as a pending list, retires
// one per observed CS pulse (in order), keeps a shadow memory and an expected
// read-data list that every response handshake is compared against.
module tb_sync_ram_ctrl;

  localparam int unsigned AW    = 2;
  localparam int unsigned DW    = 8;
  localparam int unsigned QL2   = 1;
  localparam int unsigned RDL   = 1;
  localparam int unsigned DEPTH = 1 << QL2;

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } req_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          ram_cs;
  logic          ram_we;
  logic          ram_rd;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din;
  logic [DW-1:0] ram_dout;

  always #5 clk = ~clk;

  sync_ram_ctrl_if #(.ADDR_SIZE(AW), .DATA_SIZE(DW)) bus ();

  sync_ram_ctrl #(
    .ADDR_SIZE   (AW),
    .DATA_SIZE   (DW),
    .QDEPTH_LOG2 (QL2),
    .RD_LATENCY  (RDL)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .ram_cs   (ram_cs),
    .ram_we   (ram_we),
    .ram_rd   (ram_rd),
    .ram_addr (ram_addr),
    .ram_din  (ram_din),
    .ram_dout (ram_dout)
  );

  // synchronous_ram: write on CS&WE, dataOut registered one clock after CS&RD.
  logic [DW-1:0] ramMem [1 << AW];
  always_ff @(posedge clk) begin
    if (ram_cs && ram_we) ramMem[ram_addr] <= ram_din;
    if (ram_cs && ram_rd) ram_dout <= ramMem[ram_addr];
  end

  int            nAsserts = 0;
  int            nFail    = 0;
  int            strobeErr = 0;
  bit            prevCs   = 1'b0;
  bit            sawStall = 1'b0;
  bit            randBp   = 1'b0;
  req_t          pendQ [$];
  logic [DW-1:0] expQ [$];
  logic [DW-1:0] rspLog [$];
  logic [DW-1:0] refMem [1 << AW];
  logic [DW-1:0] lastW [1 << AW];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nAsserts++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: account handshakes before the edge, observe the RAM side after.
  task automatic tick();
    req_t r;
    if (bus.rsp_valid && bus.rsp_ready) begin
      rspLog.push_back(bus.rsp_data);
      if (expQ.size() == 0) check("rsp_unexpected", 32'(expQ.size()), 32'd1);
      else check("rsp_data", 32'(bus.rsp_data), 32'(expQ.pop_front()));
    end
    if (bus.req_valid && bus.req_ready) begin
      r.we   = bus.req_we;
      r.addr = bus.req_addr;
      r.data = bus.req_wdata;
      pendQ.push_back(r);
    end
    @(posedge clk);
    #1;
    if (ram_cs) begin
      if (prevCs) strobeErr++;
      if (pendQ.size() == 0) check("issue_unexpected", 32'(pendQ.size()), 32'd1);
      else begin
        r = pendQ.pop_front();
        check("issue_we", 32'(ram_we), 32'(r.we));
        check("issue_rd", 32'(ram_rd), 32'(!r.we));
        check("issue_addr", 32'(ram_addr), 32'(r.addr));
        if (r.we) begin
          check("issue_din", 32'(ram_din), 32'(r.data));
          refMem[r.addr] = r.data;
        end else begin
          expQ.push_back(refMem[r.addr]);
        end
      end
    end else if (ram_we || ram_rd) begin
      strobeErr++;
    end
    prevCs = ram_cs;
    check("req_ready", 32'(bus.req_ready), 32'(pendQ.size() < DEPTH));
  endtask

  task automatic sendReq(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    int budget = 200;
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = a;
    bus.req_wdata = d;
    while (!bus.req_ready && budget > 0) begin
      sawStall = 1'b1;
      if (randBp) bus.rsp_ready = ($urandom_range(0, 3) != 0);
      tick();
      budget--;
    end
    if (budget == 0) check("req_timeout", 32'(bus.req_ready), 32'd1);
    else tick();
    bus.req_valid = 1'b0;
  endtask

  task automatic waitRspValid(output int n);
    n = 0;
    while (!bus.rsp_valid && n < 100) begin
      tick();
      n++;
    end
    if (!bus.rsp_valid) check("rsp_timeout", 32'(bus.rsp_valid), 32'd1);
  endtask

  task automatic drain();
    int n = 0;
    bus.rsp_ready = 1'b1;
    while ((pendQ.size() != 0 || expQ.size() != 0 || bus.rsp_valid) && n < 500) begin
      tick();
      n++;
    end
    check("drain_done", 32'(pendQ.size() + expQ.size()), 32'd0);
    tick();
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat;
    logic [AW-1:0] a;

    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.rsp_ready = 1'b1;

    // 1: reset
    reset = 1'b1;
    #10;
    reset = 1'b0;
    #1;
    check("rst_cs", 32'(ram_cs), 32'd0);
    check("rst_we", 32'(ram_we), 32'd0);
    check("rst_rd", 32'(ram_rd), 32'd0);
    check("rst_addr", 32'(ram_addr), 32'd0);
    check("rst_din", 32'(ram_din), 32'd0);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_rsp_data", 32'(bus.rsp_data), 32'd0);
    check("rst_req_ready", 32'(bus.req_ready), 32'd1);
    @(posedge clk);
    #1;

    // 2: write then read, single-clock strobe and read latency
    sendReq(1'b1, 2'b01, 8'hCC);
    tick();
    check("t2_wr_cs", 32'(ram_cs), 32'd1);
    check("t2_wr_we", 32'(ram_we), 32'd1);
    tick();
    check("t2_wr_cs_off", 32'(ram_cs), 32'd0);
    sendReq(1'b0, 2'b01, 8'h00);
    lat = 0;
    while (!bus.rsp_valid && lat < 20) begin
      tick();
      lat++;
    end
    check("t2_rd_latency", 32'(lat), 32'(RDL + 2));
    check("t2_rd_data", 32'(bus.rsp_data), 32'hCC);
    tick();
    check("t2_rsp_drop", 32'(bus.rsp_valid), 32'd0);

    // 3: back-to-back requests fill the queue; responses in order
    sawStall = 1'b0;
    rspLog.delete();
    sendReq(1'b1, 2'b10, 8'hF0);
    sendReq(1'b1, 2'b11, 8'h0F);
    sendReq(1'b0, 2'b10, 8'h00);
    sendReq(1'b0, 2'b11, 8'h00);
    check("t3_full_stall", 32'(sawStall), 32'd1);
    drain();
    check("t3_rsp_count", 32'(rspLog.size()), 32'd2);
    if (rspLog.size() == 2) begin
      check("t3_rsp0", 32'(rspLog[0]), 32'hF0);
      check("t3_rsp1", 32'(rspLog[1]), 32'h0F);
    end

    // 4: response backpressure holds data and blocks the next issue
    bus.rsp_ready = 1'b0;
    sendReq(1'b0, 2'b01, 8'h00);
    waitRspValid(lat);
    sendReq(1'b1, 2'b00, 8'h11);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t4_hold_valid", 32'(bus.rsp_valid), 32'd1);
      check("t4_hold_data", 32'(bus.rsp_data), 32'hCC);
      check("t4_no_strobe", 32'(ram_cs), 32'd0);
    end
    bus.rsp_ready = 1'b1;
    tick();
    check("t4_accept_drop", 32'(bus.rsp_valid), 32'd0);
    drain();

    // 5: pointer wrap: six writes, then read every address
    for (int i = 0; i < 6; i++) begin
      a = AW'(i);
      lastW[a] = DW'($urandom);
      sendReq(1'b1, a, lastW[a]);
    end
    rspLog.delete();
    for (int i = 0; i < (1 << AW); i++) sendReq(1'b0, AW'(i), 8'h00);
    drain();
    check("t5_rsp_count", 32'(rspLog.size()), 32'(1 << AW));
    if (rspLog.size() == (1 << AW)) begin
      for (int i = 0; i < (1 << AW); i++) check("t5_last_write", 32'(rspLog[i]), 32'(lastW[i]));
    end

    // Randomized traffic with random response backpressure
    randBp = 1'b1;
    for (int i = 0; i < 60; i++) begin
      bus.rsp_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 3) == 0) tick();
      sendReq(1'($urandom_range(0, 1)), AW'($urandom), DW'($urandom));
    end
    randBp = 1'b0;
    drain();

    // 6: reset during RD_WAIT flushes everything
    sendReq(1'b1, 2'b01, 8'hCC);
    drain();
    sendReq(1'b0, 2'b01, 8'h00);
    sendReq(1'b1, 2'b10, 8'h55);
    tick();
    reset = 1'b1;
    #1;
    check("t6_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("t6_cs", 32'(ram_cs), 32'd0);
    check("t6_rd", 32'(ram_rd), 32'd0);
    check("t6_we", 32'(ram_we), 32'd0);
    check("t6_req_ready", 32'(bus.req_ready), 32'd1);
    pendQ.delete();
    expQ.delete();
    prevCs = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t6_post_valid", 32'(bus.rsp_valid), 32'd0);
      check("t6_post_cs", 32'(ram_cs), 32'd0);
    end
    sendReq(1'b0, 2'b01, 8'h00);
    waitRspValid(lat);
    check("t6_read_back", 32'(bus.rsp_data), 32'hCC);
    sendReq(1'b0, 2'b10, 8'h00);
    drain();

    check("strobe_protocol", 32'(strobeErr), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
    $finish;
  end

endmodule
